// File: rtl/seq_booth_multiplier_ks_if.sv
// Handshake bundle for seq_booth_multiplier_ks: operand beat in, product beat out.
// master = producer/consumer side, slave = the multiplier.
interface seq_booth_multiplier_ks_if #(
  parameter int unsigned WIDTH = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_booth_multiplier_ks.sv
// Iterative Booth multiplier (signed/unsigned per beat) reusing one Kogge-Stone adder.
// Define BOOTH_RADIX4_EN for radix-4 modified Booth; default build is radix-2.
module seq_booth_multiplier_ks #(
  parameter int unsigned WIDTH = 9
) (
  input logic                    clk,
  input logic                    rst,
  seq_booth_multiplier_ks_if.slave bus
);

  localparam int unsigned W1 = WIDTH + 1;  // operands after sign/zero extension
  localparam int unsigned AW = WIDTH + 3;  // accumulator / adder width, room for 2M
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned N  = (W1 + 1) / 2;
  localparam int unsigned SH = 2;
`else
  localparam int unsigned N  = W1;
  localparam int unsigned SH = 1;
`endif
  localparam int unsigned QW = N * SH;     // multiplier register, consumed SH bits per step
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [W1-1:0]       m_q, m_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [QW-1:0]       q_q, q_d;
  logic                qm1_q, qm1_d;
  logic [2*WIDTH-1:0]  p_q, p_d;

  logic [W1-1:0]       a_ext, b_ext;
  logic [AW-1:0]       m_ext, m_two, addend_raw, addend, sum;
  logic                sel_zero, sel_neg, sel_two, cin;
  logic signed [AW+QW:0] shifted;

  assign a_ext = {bus.is_signed & bus.a[WIDTH-1], bus.a};
  assign b_ext = {bus.is_signed & bus.b[WIDTH-1], bus.b};
  assign m_ext = AW'($signed(m_q));
  assign m_two = {m_ext[AW-2:0], 1'b0};

  // Booth digit decode from the low multiplier bits plus the shifted-out bit
  always_comb begin
    sel_zero = 1'b1;
    sel_neg  = 1'b0;
    sel_two  = 1'b0;
`ifdef BOOTH_RADIX4_EN
    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: sel_zero = 1'b0;
      3'b011:         begin sel_zero = 1'b0; sel_two = 1'b1; end
      3'b100:         begin sel_zero = 1'b0; sel_two = 1'b1; sel_neg = 1'b1; end
      3'b101, 3'b110: begin sel_zero = 1'b0; sel_neg = 1'b1; end
      default:        sel_zero = 1'b1;
    endcase
`else
    case ({q_q[0], qm1_q})
      2'b01:   sel_zero = 1'b0;
      2'b10:   begin sel_zero = 1'b0; sel_neg = 1'b1; end
      default: sel_zero = 1'b1;
    endcase
`endif
    addend_raw = sel_zero ? '0 : (sel_two ? m_two : m_ext);
    addend     = sel_neg ? ~addend_raw : addend_raw;
    cin        = sel_neg;
  end

  // Kogge-Stone prefix adder; carry-in folded into bit 0 generate
  always_comb begin
    logic [AW-1:0] pr;
    logic [AW-2:0] g, pp;
    pr    = acc_q ^ addend;
    g     = acc_q[AW-2:0] & addend[AW-2:0];
    pp    = pr[AW-2:0];
    g[0]  = g[0] | (pr[0] & cin);
    for (int d = 1; d < int'(AW - 1); d = d * 2) begin
      for (int i = int'(AW) - 2; i >= d; i--) begin
        g[i]  = g[i] | (pp[i] & g[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    sum = pr ^ {g, cin};
  end

  assign shifted = $signed({sum, q_q, qm1_q}) >>> SH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          m_d     = a_ext;
          q_d     = QW'($signed(b_ext));
          qm1_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = CW'(N);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          acc_d = shifted[AW+QW:QW+1];
          q_d   = shifted[QW:1];
          qm1_d = shifted[0];
          cnt_d = cnt_q - 1'b1;
        end else begin
          // {acc, q} now holds the full product; keep the low 2*WIDTH bits
          p_d     = {acc_q[2*WIDTH-QW-1:0], q_q};
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      p_q     <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_booth_multiplier_ks.sv
// Directed + randomised self-checking bench for seq_booth_multiplier_ks (WIDTH=9).
module tb_seq_booth_multiplier_ks;
  localparam int unsigned W = 9;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 11;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  seq_booth_multiplier_ks_if #(.WIDTH(W)) bus ();
  seq_booth_multiplier_ks #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand beat, then wait for out_valid; operands are scrambled during BUSY.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output int lat, output logic [2*W-1:0] res);
    int w;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    bus.a = a; bus.b = b; bus.is_signed = s; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.is_signed = ~s;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (lat >= 40) chk("done_timeout", {63'd0, bus.out_valid}, 64'd1);
    res = bus.p;
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] res;
    logic never_valid;
    logic [W-1:0] ra, rb;
    logic rs;
    logic signed [63:0] gold;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_p", {46'd0, bus.p}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    run_op(9'h100, 9'h100, 1'b1, lat, res);
    chk("s_m256_sq", {46'd0, res}, 64'h10000);
    chk("latency", lat, LAT);
    chk("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("done_busy", {63'd0, bus.busy}, 64'd1);
    release_op();

    run_op(9'h0FF, 9'h1FF, 1'b1, lat, res);
    chk("s_255_m1", {46'd0, res}, 64'h3FF01);
    release_op();
    run_op(9'h0FF, 9'h1FF, 1'b0, lat, res);
    chk("u_255_511", {46'd0, res}, 64'h1FD01);
    release_op();
    run_op(9'h1FF, 9'h1FF, 1'b0, lat, res);
    chk("u_511_511", {46'd0, res}, 64'h3FC01);
    release_op();
    run_op(9'h000, 9'h1AB, 1'b0, lat, res);
    chk("u_zero", {46'd0, res}, 64'h0);
    release_op();

    // Backpressure: -1 * -1 held for five cycles
    run_op(9'h1FF, 9'h1FF, 1'b1, lat, res);
    chk("s_m1_m1", {46'd0, res}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_p", {46'd0, bus.p}, 64'h1);
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    release_op();
    chk("bp_rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_rel_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("bp_rel_busy", {63'd0, bus.busy}, 64'd0);

    // Reset during BUSY
    bus.a = 9'd5; bus.b = 9'd5; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_post_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("mid_post_busy", {63'd0, bus.busy}, 64'd0);
    never_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) never_valid = 1'b0;
    end
    chk("mid_no_out_valid", {63'd0, never_valid}, 64'd1);
    run_op(9'd7, 9'h1FD, 1'b1, lat, res);
    chk("s_7_m3", {46'd0, res}, 64'h3FFEB);
    chk("latency_after_rst", lat, LAT);
    release_op();

    for (int t = 0; t < 1000; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, lat, res);
      if (rs) gold = 64'(signed'(ra)) * 64'(signed'(rb));
      else    gold = $signed({55'd0, ra}) * $signed({55'd0, rb});
      chk("rand_p", {46'd0, res}, {46'd0, gold[2*W-1:0]});
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_op();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
